mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/mmio_uart_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the memory-mapped peripherals: register offsets
// inside a peripheral's 8-byte window, STATUS bit positions and the UART
// transmitter state encoding.
//
// Configuration macro: MMIO_UART_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package mmio_pkg;

  // Register offsets within the 2-word window
  localparam logic [2:0] TXDATA_OFF = 3'h0;
  localparam logic [2:0] STATUS_OFF = 3'h4;

  // STATUS register bit positions
  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_PARITY   = 4;

  // Serializer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  // Even parity of a data byte: the parity bit makes the total count of ones even
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and an occupancy counter.
// A push while full is accepted only if a pop happens in the same cycle,
// in which case the freed slot is reused immediately.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (data bits)
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   push   in   write din this cycle
//   pop    in   drop the head entry this cycle
//   din    in   WIDTH write data
//   dout   out  WIDTH head entry (valid while not empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  occupancy, clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  // Storage has no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wptr_q] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (doPop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter for a single-cycle CPU. Two registers sit
// at BASE_ADDR: TXDATA (+0, write pushes a byte into the TX FIFO) and STATUS
// (+4, {overflow, busy, full, empty}, bit 4 = parity build flag, writing 1
// to bit 3 clears overflow). Frames are 8N1, or 8E1 with parity enabled.
//
// Configuration macro: MMIO_UART_PARITY_EN adds an even parity bit.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   MemWrite    in   CPU store strobe
//   Mem_WrAddr  in   32-bit CPU data address (reads and writes)
//   Mem_WrData  in   32-bit CPU store data
//   sel         out  address falls in this peripheral's window
//   ReadData    out  32-bit combinational register read data
//   tx          out  registered serial line, idle high
//   busy        out  FIFO non-empty or frame in flight
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        sel,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);

  import mmio_pkg::*;

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
`ifdef MMIO_UART_PARITY_EN
  logic        par_q, par_d;
`endif

  logic          fifoPush;
  logic          fifoPop;
  logic [7:0]    fifoDout;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic          wrTxData;
  logic          wrStatus;
  logic          pushDropped;
  logic [31:0]   status;
  logic          unusedBits;

  // Address decode: the window is 8 bytes, bit 2 picks the register
  assign sel      = (Mem_WrAddr[31:3] == BASE_ADDR[31:3]);
  assign wrTxData = sel & MemWrite & (Mem_WrAddr[2] == TXDATA_OFF[2]);
  assign wrStatus = sel & MemWrite & (Mem_WrAddr[2] == STATUS_OFF[2]);
  assign fifoPush = wrTxData;

  // A push is lost only when full and the serializer is not freeing a slot
  assign pushDropped = wrTxData & fifoFull & ~fifoPop;

  assign unusedBits = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (Mem_WrData[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. Each bit starts with the counter at CLK_DIV-1 and ends
  // on the cycle it reaches zero. Loading a byte pops the FIFO head.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fifoPop = 1'b0;
    ovf_d   = ovf_q;
`ifdef MMIO_UART_PARITY_EN
    par_d   = par_q;
`endif

    if (wrStatus && Mem_WrData[ST_OVERFLOW]) begin
      ovf_d = 1'b0;
    end
    if (pushDropped) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoDout;
          cnt_d   = BIT_RELOAD;
          state_d = START;
`ifdef MMIO_UART_PARITY_EN
          par_d   = evenParity(fifoDout);
`endif
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = BIT_RELOAD;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = BIT_RELOAD;
          if (idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = BIT_RELOAD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Back-to-back frames go straight from STOP to the next START
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            shift_d = fifoDout;
            cnt_d   = BIT_RELOAD;
            state_d = START;
`ifdef MMIO_UART_PARITY_EN
            par_d   = evenParity(fifoDout);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: tx is computed from the next state so the registered line
  // changes on the same edge the state does.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy = (fifoCount != '0) || (state_q != IDLE);

    status              = '0;
    status[ST_EMPTY]    = fifoEmpty;
    status[ST_FULL]     = fifoFull;
    status[ST_BUSY]     = busy;
    status[ST_OVERFLOW] = ovf_q;
`ifdef MMIO_UART_PARITY_EN
    status[ST_PARITY]   = 1'b1;
`endif
  end

  assign tx       = tx_q;
  assign ReadData = (sel && (Mem_WrAddr[2] == STATUS_OFF[2])) ? status : 32'h0;

endmodule
